// File: rtl/my_div32_seq.sv
// Iterative radix-2 restoring unsigned divider with valid/ready on both sides.
// One quotient bit per clock, MSB first; result is {remainder, quotient}.
module my_div32_seq #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   dataa,
  input  logic [W-1:0]   datab,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] dataout,
  output logic           div_by_zero
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;       // dividend shifts out MSB-first, quotient bits shift in
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     r_q, r_d;
  logic [2*W-1:0]   dout_q, dout_d;
  logic             dbz_q, dbz_d;

  logic [W:0]       r_shift;
  logic [W:0]       r_sub;
  logic             q_bit;

  // The extra top bit keeps the shifted-out remainder MSB so the compare never loses a carry.
  always_comb begin
    r_shift = {r_q, a_q[W-1]};
    r_sub   = r_shift - {1'b0, b_q};
    q_bit   = (r_shift >= {1'b0, b_q});
  end

  // NOTE: every variable gets a hold default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    dout_d  = dout_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (datab == '0) begin
            dout_d  = {dataa, {W{1'b1}}};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = dataa;
            b_d     = datab;
            r_d     = '0;
            cnt_d   = CNT_MAX;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d = q_bit ? r_sub[W-1:0] : r_shift[W-1:0];
        a_d = {a_q[W-2:0], q_bit};
        if (cnt_q == '0) begin
          dout_d  = {r_d, a_d};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      dout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      dout_q  <= dout_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign dataout     = dout_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_my_div32_seq.sv
// Scoreboard bench for my_div32_seq: the driver pushes expected results from a
// plain-arithmetic model, an independent monitor pops them on each output handshake.
module tb_my_div32_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [2*W-1:0] dout;
    logic           dbz;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   dataa = '0;
  logic [W-1:0]   datab = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] dataout;
  logic           div_by_zero;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  my_div32_seq #(.W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dataa       (dataa),
    .datab       (datab),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dataout     (dataout),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.dout = {a, {W{1'b1}}};
      e.dbz  = 1'b1;
    end else begin
      e.dout = {a % b, a / b};
      e.dbz  = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dataout", dataout, e.dout);
        check("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  // Called and returns at 1 time unit after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
      return;
    end
    in_valid = 1'b1;
    dataa    = a;
    datab    = b;
    @(posedge clk);
    if (push) exp_q.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
    dataa    = $urandom;
    datab    = $urandom;
  endtask

  // Edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < W + 20) begin
      @(posedge clk); #1; k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [W-1:0] a, b;

    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_dataout", dataout, '0);
    check("rst_dbz", div_by_zero, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic divide and latency.
    send(32'd100, 32'd7, 1'b1);
    wait_valid(k);
    check("lat_100_7", k, W);
    @(posedge clk); #1;

    send(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_valid(k);
    send(32'd5, 32'd9, 1'b1);
    wait_valid(k);
    check("lat_5_9", k, W);

    // Divide by zero: out_valid is up right after the accepting edge.
    send(32'd1234, 32'd0, 1'b1);
    wait_valid(k);
    check("lat_dbz", k, 0);
    @(posedge clk); #1;

    // Backpressure: result held, in_valid ignored while DONE.
    ready_mode = 0;
    @(posedge clk); #1;
    send(32'd100, 32'd7, 1'b1);
    wait_valid(k);
    check("bp_valid", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      dataa    = $urandom;
      datab    = $urandom;
      @(posedge clk); #1;
      check("bp_dataout", dataout, {32'd2, 32'd14});
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
    end
    in_valid   = 1'b0;
    ready_mode = 1;
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_out_valid", out_valid, 1'b0);

    // Asynchronous reset in the middle of RUN.
    send(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_dataout", dataout, '0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", out_valid, 1'b0);
    end
    send(32'd100, 32'd7, 1'b1);
    wait_valid(k);
    check("post_rst_lat", k, W);
    @(posedge clk); #1;

    // Random regression with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'd1;
        2:       b = a;
        3:       b = $urandom_range(1, 15);
        4:       b = (a == '1) ? a : a + 1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      send(a, b, 1'b1);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
